// File: rtl/disp_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl_pkg
//   Shared constants and types for the multiplexed seven-segment scan logic.
//   - AN_OFF        : inactive level of an anode line (anodes are active-low)
//   - scan_state_e  : per-slot phase, BLANK (all anodes off) then DRIVE
//   - DEF_PRESCALE  : cycles per digit slot for a 100 MHz clock, ~1 kHz per slot
//   - DEF_BLANK_CYC : dead time at the start of each slot (10 us at 100 MHz)
// -----------------------------------------------------------------------------
package disp_scan_ctrl_pkg;

  localparam logic AN_OFF = 1'b1;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam int DEF_PRESCALE  = 100_000;
  localparam int DEF_BLANK_CYC = 1_000;

endpackage

// File: rtl/disp_scan_ctrl_slot_timer.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl_slot_timer
//   Slot prescaler and BLANK/DRIVE phase machine for the display scanner.
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   synchronous active-high reset
//     en         in   scan enable; low clears the prescaler and forces BLANK
//     slot_end   out  high in the last cycle of a slot (cnt == PRESCALE-1, en=1)
//     drive_next out  phase of the NEXT cycle is DRIVE; lets the parent register
//                     the anode pattern in step with the counter
// -----------------------------------------------------------------------------
module disp_scan_ctrl_slot_timer
  import disp_scan_ctrl_pkg::*;
#(
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic slot_end,
  output logic drive_next
);

  localparam int CNT_W = $clog2(PRESCALE);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic             NO_BLANK  = (BLANK_CYC == 0);

  localparam logic [0:0] ST_BLANK = BLANK;
  localparam logic [0:0] ST_DRIVE = DRIVE;
  // With no dead time a wrapping slot goes straight back into DRIVE.
  localparam logic [0:0] ST_AFTER_WRAP = NO_BLANK ? ST_DRIVE : ST_BLANK;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_end = en && (cnt_q == CNT_LAST);
    cnt_d    = cnt_q + 1'b1;
    state_d  = state_q;
    if (!en) begin
      cnt_d   = '0;
      state_d = ST_BLANK;
    end else if (slot_end) begin
      cnt_d   = '0;
      state_d = ST_AFTER_WRAP;
    end else if (state_q == ST_BLANK && (NO_BLANK || cnt_d == CNT_BLANK)) begin
      // BLANK is only ever entered with cnt at 0, so counting up to the
      // dead-time length is the only way out; with no dead time the very
      // first count after a clear/resume already leaves BLANK.
      state_d = ST_DRIVE;
    end
    drive_next = (state_d == ST_DRIVE);
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= ST_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl
//   Multiplexed seven-segment scan controller. Steps a digit index through
//   0..N_DIGITS-1, one slot of PRESCALE cycles per digit, and drives the
//   active-low one-hot anodes with a dead time of BLANK_CYC cycles at the start
//   of every slot.
//   Ports:
//     clk         in   system clock, rising edge
//     rst         in   synchronous active-high reset
//     en          in   scan enable; low = display dark and scan frozen
//     digit_mask  in   1 = digit may be lit; 0 = kept dark, slot still used
//     rc          out  current digit index, feeds the segment mux
//     an          out  anode drive, active-low one-hot, all ones = all off
//     slot_start  out  one-cycle pulse in the first cycle of a new rc
//     frame_start out  slot_start for the slot where rc returns to 0
// -----------------------------------------------------------------------------
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter  int N_DIGITS  = 8,
  parameter  int PRESCALE  = DEF_PRESCALE,
  parameter  int BLANK_CYC = DEF_BLANK_CYC,
  localparam int IDX_W     = $clog2(N_DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_DIGITS-1:0] digit_mask,
  output logic [IDX_W-1:0]    rc,
  output logic [N_DIGITS-1:0] an,
  output logic                slot_start,
  output logic                frame_start
);

  localparam logic [IDX_W-1:0] RC_LAST = IDX_W'(N_DIGITS - 1);

  logic slot_end;
  logic drive_next;

  disp_scan_ctrl_slot_timer #(
    .PRESCALE (PRESCALE),
    .BLANK_CYC(BLANK_CYC)
  ) u_slot_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .slot_end  (slot_end),
    .drive_next(drive_next)
  );

  logic [IDX_W-1:0]    rc_q, rc_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                slot_start_q, slot_start_d;
  logic                frame_start_q, frame_start_d;

  always_comb begin
    rc_d = rc_q;
    if (slot_end) begin
      // Explicit wrap keeps rc inside 0..N_DIGITS-1 for non-power-of-two counts.
      rc_d = (rc_q == RC_LAST) ? '0 : rc_q + 1'b1;
    end
    slot_start_d  = slot_end;
    frame_start_d = slot_end && (rc_q == RC_LAST);

    // Decoded from next-state rc/phase so an and rc change on the same edge.
    an_d = {N_DIGITS{AN_OFF}};
    if (drive_next && digit_mask[rc_d]) begin
      an_d[rc_d] = ~AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q          <= '0;
      an_q          <= {N_DIGITS{AN_OFF}};
      slot_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rc_q          <= rc_d;
      an_q          <= an_d;
      slot_start_q  <= slot_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign rc          = rc_q;
  assign an          = an_q;
  assign slot_start  = slot_start_q;
  assign frame_start = frame_start_q;

endmodule
